// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, finds the middle of each bit, and issues
// one-cycle valid / frame_err strobes. A low stop bit parks the FSM until the line idles.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
  logic                   rs;

  assign rs        = sync_q[SYNC_STAGES-1];
  assign dbg_state = state;

  // Handshake: valid and frame_err are single-cycle pulses with no back-pressure;
  // a consumer must capture data in the cycle valid is high (data then holds anyway).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (!ena) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!rs) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (cnt == HALF_M1) begin
              cnt <= '0;
              if (rs) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state   <= DATA;
                bit_idx <= '0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (cnt == FULL_M1) begin
              cnt     <= '0;
              shift   <= {rs, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            if (cnt == FULL_M1) begin
              cnt <= '0;
              if (rs) begin
                data  <= shift;
                valid <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK_WAIT;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          BREAK_WAIT: begin
            // One error per low period, however long the break lasts.
            if (rs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are described as bytes, the expected strobe
// stream (kind, byte, cycle) is queued by the driver and matched every cycle.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] dbg_state;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_fail = 0;
  logic       chk_en = 1'b0;
  logic [8:0] exp_q[$];
  int         exp_cyc_q[$];
  int         pulse_cyc[$];
  logic [7:0] model_data = 8'h00;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         t_start = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // driver tasks
  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_busy(input logic b);
    rx = b;
    for (int k = 0; k < CPB; k++) begin
      @(posedge clk);
      #1;
      if (k == CPB / 2) check("busy_mid_bit", busy, 1);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic expect_pulse);
    t_start = cyc + 1;
    if (expect_pulse) begin
      exp_q.push_back({~stop, b});
      exp_cyc_q.push_back(t_start + LAT);
    end
    hold_busy(1'b0);
    for (int i = 0; i < 8; i++) hold_busy(b[i]);
    hold_busy(stop);
  endtask

  // scoreboard: every cycle, strobes against queue, data against last good byte
  always @(negedge clk) begin
    logic [8:0] e;
    int         ec;
    if (chk_en) begin
      check("no_dual_strobe", int'(valid & frame_err), 0);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", int'({valid, frame_err}), 0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("pulse_kind", int'(frame_err), int'(e[8]));
          check_range("pulse_latency", cyc, ec - 1, ec + 1);
          if (valid) begin
            check("data_on_valid", data, e[7:0]);
            model_data = e[7:0];
            n_valid++;
          end else begin
            check("data_on_ferr", data, model_data);
            n_ferr++;
          end
          pulse_cyc.push_back(cyc);
        end
      end else begin
        check("data_hold", data, model_data);
        if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0] + 1) begin
          check("pulse_missing", 0, 1);
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
      if (!rst_n) model_data = 8'h00;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("reset_data", data, 8'h00);
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_ferr", frame_err, 0);
    hold(1'b1, 20);

    // single 0x55 frame
    send_frame(8'h55, 1'b1, 1'b1);
    hold(1'b1, CPB);
    check("t1_valid_count", n_valid, 1);
    check("t1_ferr_count", n_ferr, 0);
    check("t1_data", data, 8'h55);
    check("t1_busy_idle", busy, 0);
    check_range("t1_latency", pulse_cyc[pulse_cyc.size()-1] - t_start, 154, 156);

    // back-to-back, zero idle bits
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(1'b1, CPB);
    check("t2_valid_count", n_valid, 3);
    check("t2_data", data, 8'h3C);
    check_range("t2_gap", pulse_cyc[2] - pulse_cyc[1], 159, 161);

    // 5-cycle glitch
    hold(1'b0, 5);
    hold(1'b1, 2 * CPB);
    check("t3_busy", busy, 0);
    check("t3_valid_count", n_valid, 3);
    check("t3_ferr_count", n_ferr, 0);
    check("t3_data", data, 8'h3C);

    // framing error then long break
    send_frame(8'h81, 1'b0, 1'b1);
    hold(1'b0, 40 * CPB);
    hold(1'b1, 2 * CPB);
    check("t4_ferr_count", n_ferr, 1);
    check("t4_valid_count", n_valid, 3);
    check("t4_data", data, 8'h3C);
    check("t4_busy", busy, 0);
    send_frame(8'h7E, 1'b1, 1'b1);
    hold(1'b1, CPB);
    check("t4_next_data", data, 8'h7E);
    check("t4_next_count", n_valid, 4);

    // reset during data bit 4 of 0xFF
    hold_busy(1'b0);
    for (int i = 0; i < 4; i++) hold_busy(1'b1);
    hold(1'b1, 8);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t5_busy", busy, 0);
    check("t5_data", data, 8'h00);
    hold(1'b1, 7 + 4 * CPB);
    hold(1'b1, CPB);
    check("t5_valid_count", n_valid, 4);
    send_frame(8'h12, 1'b1, 1'b1);
    hold(1'b1, CPB);
    check("t5_next_data", data, 8'h12);
    check("t5_next_count", n_valid, 5);

    // ena dropped during bit 2 of 0x96
    hold_busy(1'b0);
    hold_busy(1'b0);
    hold_busy(1'b1);
    hold(1'b1, 8);
    ena = 1'b0;
    @(posedge clk);
    #1;
    check("t6_busy_drop", busy, 0);
    hold(1'b1, 7);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, 3 * CPB);
    ena = 1'b1;
    hold(1'b1, CPB);
    check("t6_valid_count", n_valid, 5);
    check("t6_ferr_count", n_ferr, 1);
    check("t6_data", data, 8'h12);
    send_frame(8'hC3, 1'b1, 1'b1);
    hold(1'b1, CPB);
    check("t6_next_data", data, 8'hC3);
    check("t6_next_count", n_valid, 6);

    hold(1'b1, 20);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
